// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b LSB-first, one bit per clock, over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    assign w_x        = r_a[0];
    assign w_y        = r_b[0];
    assign w_d        = w_x ^ w_y ^ r_bin;
    assign w_bout     = (~w_x & w_y) | (~(w_x ^ w_y) & r_bin);
    // New bits enter at the MSB so the last processed bit lands in diff[WIDTH-1].
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state != S_RUN && start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == S_RUN && r_cnt == LAST_BIT) begin
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_res   <= '0;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_bin <= w_bout;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_bout;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8); ovf checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_diff = 8'h00;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    #2;
    total++;
    if ({busy, done, borrow} !== 3'b000 || diff !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b borrow=%b diff=%h want 0 0 0 00",
               busy, done, borrow, diff);
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_diff = 8'h00;
  endtask

  // One full operation: latency, busy window, done pulse, result and hold.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL op_accept got busy=%b done=%b want 1 0", busy, done);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) a = ~ta;
      if (i < 8) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL op_run_%0d got busy=%b done=%b want 1 0", i, busy, done);
        end
        if (i == 4) begin
          total++;
          if (diff !== prev_diff) begin
            bad++;
            $display("FAIL op_diff_held_in_run got %h want %h", diff, prev_diff);
          end
        end
      end else begin
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL op_done_edge got done=%b busy=%b want 1 0", done, busy);
        end
        total++;
        if (diff !== ed || borrow !== eb) begin
          bad++;
          $display("FAIL op_result %h-%h got diff=%h borrow=%b want diff=%h borrow=%b",
                   ta, tb_v, diff, borrow, ed, eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf !== eo) begin
          bad++;
          $display("FAIL op_ovf %h-%h got %b want %b", ta, tb_v, ovf, eo);
        end
`else
        if (eo !== eo) $display("unused");
`endif
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== ed || borrow !== eb) begin
      bad++;
      $display("FAIL op_idle_hold got done=%b busy=%b diff=%h borrow=%b want 0 0 %h %b",
               done, busy, diff, borrow, ed, eb);
    end
    prev_diff = ed;
  endtask

  task automatic test_basic();
    run_op(8'd10, 8'd3, 8'h07, 1'b0, 1'b0);
    run_op(8'd3, 8'd10, 8'hF9, 1'b1, 1'b0);
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_ovf();
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
  endtask

  task automatic test_ignore_start();
    int dcount;
    dcount = 0;
    @(negedge clk);
    a = 8'd20;
    b = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
      if (i == 3) begin
        start = 1'b1;
        a = 8'hAA;
        b = 8'h00;
      end
      if (i == 4) start = 1'b0;
      if (i == 8) begin
        total++;
        if (done !== 1'b1 || diff !== 8'h0F || borrow !== 1'b0) begin
          bad++;
          $display("FAIL ignore_result got done=%b diff=%h borrow=%b want 1 0f 0",
                   done, diff, borrow);
        end
      end
    end
    total++;
    if (dcount != 1) begin
      bad++;
      $display("FAIL ignore_single_done got %0d pulses want 1", dcount);
    end
    prev_diff = 8'h0F;
  endtask

  task automatic test_reset_abort();
    int dcount;
    dcount = 0;
    @(negedge clk);
    a = 8'd10;
    b = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset got busy=%b done=%b diff=%h borrow=%b want 0 0 00 0",
               busy, done, diff, borrow);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    total++;
    if (dcount != 0) begin
      bad++;
      $display("FAIL abort_no_done got %0d active cycles want 0", dcount);
    end
    prev_diff = 8'h00;
    run_op(8'd1, 8'd1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    @(negedge clk);
    a = 8'd9;
    b = 8'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk);
      #1;
      exp_done = (i % 9 == 8);
      total++;
      if (done !== exp_done || busy !== !exp_done) begin
        bad++;
        $display("FAIL b2b_cycle_%0d got done=%b busy=%b want %b %b",
                 i, done, busy, exp_done, !exp_done);
      end
      if (exp_done) begin
        total++;
        if (diff !== 8'h05 || borrow !== 1'b0) begin
          bad++;
          $display("FAIL b2b_result_%0d got diff=%h borrow=%b want 05 0", i, diff, borrow);
        end
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop got busy=%b done=%b want 0 0", busy, done);
    end
    prev_diff = 8'h05;
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port: a  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL have port: busy  output  1  operation in progress.
REQ-008 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have port: diff  output  WIDTH  result a-b mod 2^WIDTH, held until next done.
REQ-010 SHALL have port: borrow  output  1  final borrow out (1 when a<b unsigned), held with diff.
REQ-011 SHALL have port: ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 SHALL accept start in IDLE or DONE (busy=0): capture a, b into shift registers, clear internal borrow, clear bit counter, enter RUN.
REQ-014 SHALL ignore start while in RUN; captured operands unaffected by a/b changes after acceptance.
REQ-015 SHALL in RUN process one bit per clock LSB-first using a full-subtractor: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
REQ-016 SHALL shift each d into the result register MSB-side so the full result is aligned after WIDTH bits.
REQ-017 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; latency: start sampled at edge k -> DONE entered at edge k+WIDTH.
REQ-018 SHALL drive busy=1 exactly while state is RUN (WIDTH cycles).
REQ-019 SHALL drive done=1 exactly while state is DONE (one cycle); DONE returns to IDLE next edge unless a new start is accepted there (back-to-back, -> RUN).
REQ-020 SHALL update diff and borrow only on entry to DONE; they remain stable through IDLE and the following RUN until the next DONE.
REQ-021 SHALL not modify diff/borrow for a start ignored per REQ-014.
REQ-022 SHALL handle a=b producing diff=0, borrow=0; a=0,b=2^WIDTH-1 producing diff=1, borrow=1.

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, counter and shift registers 0.
REQ-024 SHALL abort an operation in progress on reset with no done pulse; first start after rst_n release is accepted normally.

Configuration
REQ-025 SHALL use macro SERIAL_SUB_OVF_EN to compile in the ovf output.
REQ-026 SHALL, with SERIAL_SUB_OVF_EN defined, set ovf on entry to DONE to (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]) using captured operands, held with diff.
REQ-027 SHALL, without SERIAL_SUB_OVF_EN, omit the ovf port and its logic entirely; all other behaviour identical.

Verification
REQ-028 SHALL cover: WIDTH=8, a=10, b=3, start one cycle -> busy 8 cycles, done after edge k+8, diff=8'h07, borrow=0.
REQ-029 SHALL cover: a=3, b=10 -> diff=8'hF9, borrow=1; a=0, b=8'hFF -> diff=8'h01, borrow=1.
REQ-030 SHALL cover (OVF_EN): a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1; a=8'h05, b=8'h03 -> ovf=0.
REQ-031 SHALL cover: start pulsed with a=8'hAA at cycle 3 of a running a=20, b=5 -> ignored, diff=8'h0F, single done.
REQ-032 SHALL cover: rst_n low at cycle 4 of RUN -> busy=0, done never pulses, diff=0; next start a=1, b=1 -> diff=0, borrow=0.
REQ-033 SHALL cover: start held high continuously, a=9, b=4 -> done every 9 cycles, busy low only during DONE, diff=8'h05 each time.
